ram_arbiter: RTL and testbench

- Two-port round-robin arbiter that shares the single-port registered-address RAM (ram_reg) between two requesters.
- Each cycle it accepts at most one access (read or write) and drives the RAM control/data/address inputs.
- It returns read data to the winning port with a valid strobe one cycle later.
- A burst counter lets a port keep ownership for up to MAX_BURST back-to-back accesses before being forced to yield under contention.

---
 rtl/ram_arb_pkg.sv | 10 +
 rtl/ram_reg.sv | 30 +++
 rtl/rr_burst_arbiter.sv | 63 ++++++
 rtl/ram_arbiter.sv | 86 ++++++++
 tb/tb_ram_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Width of the burst counter; holds MAX_BURST values up to 15.
    localparam int unsigned BURST_W = 4;

endpackage

// File: rtl/ram_reg.sv
// Single-port RAM with registered address: write and address capture share one edge,
// so a read issued the cycle after a write to the same address sees the new word.
module ram_reg #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] addr_reg;

    // Write the array and capture the address on the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr_in] <= data_in;
        end
        addr_reg <= addr_in;
    end

    // Read through the registered address.
    always_comb begin
        data_out = mem[addr_reg];
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Two-request round-robin arbiter with a burst allowance for the current owner.
module rr_burst_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

    logic               owner;
    logic [BURST_W-1:0] burst_cnt;
    logic               keep_owner;
    logic               gnt_port;

    // Grant decision; a zero count (after idle or reset) hands contention to the non-owner.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        keep_owner = (burst_cnt != '0) && (burst_cnt < MAX_CNT);
        if (rst_n) begin
            case ({req1, req0})
                2'b01:   gnt0 = 1'b1;
                2'b10:   gnt1 = 1'b1;
                2'b11: begin
                    if (keep_owner == (owner == PORT0)) begin
                        gnt0 = 1'b1;
                    end else begin
                        gnt1 = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        gnt_port = gnt1 ? PORT1 : PORT0;
    end

    // Track owner and how many consecutive grants it has taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner     <= PORT1;
            burst_cnt <= '0;
        end else if (gnt0 || gnt1) begin
            if (gnt_port == owner) begin
                if (burst_cnt != MAX_CNT) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                owner     <= gnt_port;
                burst_cnt <= BURST_W'(1);
            end
        end else begin
            burst_cnt <= '0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one registered-address RAM between two requesters, one access per cycle,
// returning read data to the winning port one cycle after its grant.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_addr_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    logic rd_pend;
    logic rd_port;

    rr_burst_arbiter #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req0 (p0_req),
        .req1 (p1_req),
        .gnt0 (p0_gnt),
        .gnt1 (p1_gnt)
    );

    // Steer the granted port onto the RAM; idle bus is all zeros.
    always_comb begin
        ram_we      = 1'b0;
        ram_addr_in = '0;
        ram_data_in = '0;
        if (p0_gnt) begin
            ram_we      = p0_we;
            ram_addr_in = p0_addr;
            ram_data_in = p0_wdata;
        end else if (p1_gnt) begin
            ram_we      = p1_we;
            ram_addr_in = p1_addr;
            ram_data_in = p1_wdata;
        end
    end

    // Remember which port's read is in flight for the one-cycle return.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_port <= PORT0;
        end else if (p0_gnt && !p0_we) begin
            rd_pend <= 1'b1;
            rd_port <= PORT0;
        end else if (p1_gnt && !p1_we) begin
            rd_pend <= 1'b1;
            rd_port <= PORT1;
        end else begin
            rd_pend <= 1'b0;
        end
    end

    // Return path; reset masks a read still in flight.
    always_comb begin
        p0_rvalid = rst_n && rd_pend && (rd_port == PORT0);
        p1_rvalid = rst_n && rd_pend && (rd_port == PORT1);
        p0_rdata  = p0_rvalid ? ram_data_out : '0;
        p1_rdata  = p1_rvalid ? ram_data_out : '0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter driving a ram_reg, with a behavioural arbitration/memory model.
module tb_ram_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 11;
    localparam int unsigned MB = 4;

    logic          clk;
    logic          rst_n;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          ram_we;
    logic [DW-1:0] ram_data_in, ram_data_out;
    logic [AW-1:0] ram_addr_in;

    int vectors;
    int miscompares;

    // Reference model state: who last held the RAM, length of its unbroken run, memory image.
    int            m_last;
    int            m_run;
    logic [DW-1:0] m_mem   [0:(1<<AW)-1];
    bit            m_known [0:(1<<AW)-1];
    int            exp_rv;
    logic [DW-1:0] exp_rd;
    bit            exp_rd_known;

    ram_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p0_req      (p0_req),
        .p0_we       (p0_we),
        .p0_addr     (p0_addr),
        .p0_wdata    (p0_wdata),
        .p0_gnt      (p0_gnt),
        .p0_rvalid   (p0_rvalid),
        .p0_rdata    (p0_rdata),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_addr     (p1_addr),
        .p1_wdata    (p1_wdata),
        .p1_gnt      (p1_gnt),
        .p1_rvalid   (p1_rvalid),
        .p1_rdata    (p1_rdata),
        .ram_we      (ram_we),
        .ram_data_in (ram_data_in),
        .ram_addr_in (ram_addr_in),
        .ram_data_out(ram_data_out)
    );

    ram_reg #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .data_in (ram_data_in),
        .addr_in (ram_addr_in),
        .data_out(ram_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Which port should win this cycle (-1 for none).
    function automatic int model_grant(logic r0, logic r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        // Contention: the last holder keeps going only mid-run and under the burst limit.
        if (m_run >= 1 && m_run < int'(MB)) return m_last;
        return 1 - m_last;
    endfunction

    task automatic model_reset();
        m_last = 1;
        m_run  = 0;
        exp_rv = -1;
    endtask

    task automatic model_commit(int g);
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        exp_rv = -1;
        if (g < 0) begin
            m_run = 0;
        end else begin
            we = (g == 0) ? p0_we    : p1_we;
            a  = (g == 0) ? p0_addr  : p1_addr;
            d  = (g == 0) ? p0_wdata : p1_wdata;
            if (we) begin
                m_mem[a]   = d;
                m_known[a] = 1'b1;
            end else begin
                exp_rv       = g;
                exp_rd       = m_mem[a];
                exp_rd_known = m_known[a];
            end
            if (g == m_last) begin
                m_run = (m_run + 1 > int'(MB)) ? int'(MB) : m_run + 1;
            end else begin
                m_last = g;
                m_run  = 1;
            end
        end
    endtask

    // Let one clock edge happen, keeping the model in step with it.
    task automatic advance();
        if (!rst_n) model_reset();
        else model_commit(model_grant(p0_req, p1_req));
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        advance();
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        p0_req   = 1'b1; p0_we = 1'b1; p0_addr = 11'h123; p0_wdata = 8'h5A;
        p1_req   = 1'b1; p1_we = 1'b0; p1_addr = 11'h321; p1_wdata = 8'hA5;
        for (int n = 0; n < 3; n++) begin
            #1;
            vectors++;
            if ({p0_gnt, p1_gnt, ram_we, ram_addr_in, ram_data_in} !== '0) begin
                miscompares++;
                $display("FAIL reset_bus: got gnt=%b%b we=%b addr=%h data=%h required all 0",
                         p0_gnt, p1_gnt, ram_we, ram_addr_in, ram_data_in);
            end
            vectors++;
            if ({p0_rvalid, p1_rvalid, p0_rdata, p1_rdata} !== '0) begin
                miscompares++;
                $display("FAIL reset_ret: got rvalid=%b%b rdata=%h/%h required 0",
                         p0_rvalid, p1_rvalid, p0_rdata, p1_rdata);
            end
            advance();
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        rst_n  = 1'b1;
        advance();
    endtask

    task automatic test_write_seq();
        p1_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p0_req = 1'b1; p0_we = 1'b1; p0_addr = 11'(i); p0_wdata = 8'(8'h11 + i);
            #1;
            vectors++;
            if ({p0_gnt, p1_gnt, ram_we, ram_addr_in, ram_data_in} !==
                {1'b1, 1'b0, 1'b1, 11'(i), 8'(8'h11 + i)}) begin
                miscompares++;
                $display("FAIL write_seq[%0d]: got gnt=%b%b we=%b addr=%h data=%h required 10 1 %h %h",
                         i, p0_gnt, p1_gnt, ram_we, ram_addr_in, ram_data_in, 11'(i), 8'(8'h11 + i));
            end
            vectors++;
            if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
                miscompares++;
                $display("FAIL write_rvalid[%0d]: got %b%b required 00", i, p0_rvalid, p1_rvalid);
            end
            advance();
        end
        p0_req = 1'b0;
        #1;
        vectors++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL write_last_rvalid: got %b%b required 00", p0_rvalid, p1_rvalid);
        end
        advance();
    endtask

    task automatic test_read_seq();
        p1_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p0_req = (i < 4); p0_we = 1'b0; p0_addr = 11'(i);
            #1;
            if (i < 4) begin
                vectors++;
                if ({p0_gnt, ram_we, ram_addr_in} !== {1'b1, 1'b0, 11'(i)}) begin
                    miscompares++;
                    $display("FAIL read_gnt[%0d]: got gnt=%b we=%b addr=%h required 1 0 %h",
                             i, p0_gnt, ram_we, ram_addr_in, 11'(i));
                end
            end
            vectors++;
            if ({p0_rvalid, p1_rvalid, p0_rdata} !==
                {(i > 0), 1'b0, (i > 0) ? 8'(8'h11 + i - 1) : 8'h00}) begin
                miscompares++;
                $display("FAIL read_ret[%0d]: got rvalid=%b%b rdata=%h required %b0 %h", i,
                         p0_rvalid, p1_rvalid, p0_rdata, (i > 0), (i > 0) ? 8'(8'h11 + i - 1) : 8'h00);
            end
            advance();
        end
        #1;
        vectors++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL read_tail: got rvalid=%b%b required 00", p0_rvalid, p1_rvalid);
        end
    endtask

    task automatic test_contention();
        int prev;
        int expp;
        do_reset();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 11'd0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 11'd1;
        prev = -1;
        for (int k = 0; k < 12; k++) begin
            expp = (k / int'(MB)) % 2;
            #1;
            vectors++;
            if ({p0_gnt, p1_gnt} !== {(expp == 0), (expp == 1)}) begin
                miscompares++;
                $display("FAIL contention_gnt[%0d]: got %b%b required port %0d", k, p0_gnt, p1_gnt, expp);
            end
            vectors++;
            if ({p0_rvalid, p1_rvalid, p0_rdata, p1_rdata} !==
                {(prev == 0), (prev == 1), (prev == 0) ? 8'h11 : 8'h00, (prev == 1) ? 8'h12 : 8'h00}) begin
                miscompares++;
                $display("FAIL contention_ret[%0d]: got rvalid=%b%b rdata=%h/%h after port %0d",
                         k, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, prev);
            end
            prev = expp;
            advance();
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        advance();
    endtask

    task automatic test_raw();
        p0_req = 1'b0;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 11'h7FF; p1_wdata = 8'hA5;
        #1;
        vectors++;
        if ({p0_gnt, p1_gnt, ram_we, ram_addr_in} !== {1'b0, 1'b1, 1'b1, 11'h7FF}) begin
            miscompares++;
            $display("FAIL raw_write: got gnt=%b%b we=%b addr=%h required 01 1 7ff",
                     p0_gnt, p1_gnt, ram_we, ram_addr_in);
        end
        advance();
        p1_req = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 11'h7FF;
        #1;
        vectors++;
        if ({p0_gnt, p0_rvalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL raw_read_gnt: got gnt=%b rvalid=%b required 1 0", p0_gnt, p0_rvalid);
        end
        advance();
        p0_req = 1'b0;
        #1;
        vectors++;
        if ({p0_rvalid, p1_rvalid, p0_rdata} !== {2'b10, 8'hA5}) begin
            miscompares++;
            $display("FAIL raw_data: got rvalid=%b%b rdata=%h required 10 a5", p0_rvalid, p1_rvalid, p0_rdata);
        end
        advance();
    endtask

    task automatic test_idle_clears();
        p0_req = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 11'd3;
        advance();
        advance();
        p1_req = 1'b0;
        advance();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 11'd2;
        p1_req = 1'b1;
        #1;
        vectors++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL idle_clears: got gnt=%b%b required 10", p0_gnt, p1_gnt);
        end
        advance();
        #1;
        vectors++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL burst_one_keeps: got gnt=%b%b required 10", p0_gnt, p1_gnt);
        end
        advance();
        p0_req = 1'b0;
        p1_req = 1'b0;
        advance();
    endtask

    task automatic test_reset_mid();
        p1_req = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 11'd2;
        #1;
        vectors++;
        if (p0_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_gnt: got %b required 1", p0_gnt);
        end
        advance();
        rst_n  = 1'b0;
        p0_req = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (n == 2) rst_n = 1'b1;
            #1;
            vectors++;
            if ({p0_rvalid, p1_rvalid, p0_rdata} !== '0) begin
                miscompares++;
                $display("FAIL rstmid_rvalid[%0d]: got rvalid=%b%b rdata=%h required 0",
                         n, p0_rvalid, p1_rvalid, p0_rdata);
            end
            if (n < 2) advance();
        end
        p0_req = 1'b1;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 11'd1;
        #1;
        vectors++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL rstmid_first: got gnt=%b%b required 10", p0_gnt, p1_gnt);
        end
        advance();
        p0_req = 1'b0;
        p1_req = 1'b0;
        advance();
    endtask

    task automatic test_random();
        int            g;
        bit            hold0, hold1;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        hold0 = 1'b0;
        hold1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!hold0) begin
                p0_req = ($urandom_range(0, 3) != 0); p0_we = 1'($urandom_range(0, 1));
                p0_addr = 11'($urandom_range(0, 15)); p0_wdata = 8'($urandom);
            end
            if (!hold1) begin
                p1_req = ($urandom_range(0, 3) != 0); p1_we = 1'($urandom_range(0, 1));
                p1_addr = 11'($urandom_range(0, 15)); p1_wdata = 8'($urandom);
            end
            #1;
            g      = model_grant(p0_req, p1_req);
            e_we   = (g == 0) ? p0_we    : (g == 1) ? p1_we    : 1'b0;
            e_addr = (g == 0) ? p0_addr  : (g == 1) ? p1_addr  : '0;
            e_data = (g == 0) ? p0_wdata : (g == 1) ? p1_wdata : '0;
            vectors++;
            if ({p0_gnt, p1_gnt, ram_we, ram_addr_in, ram_data_in} !==
                {(g == 0), (g == 1), e_we, e_addr, e_data}) begin
                miscompares++;
                $display("FAIL rand_bus[%0d]: got gnt=%b%b we=%b addr=%h data=%h required port %0d we=%b addr=%h data=%h",
                         n, p0_gnt, p1_gnt, ram_we, ram_addr_in, ram_data_in, g, e_we, e_addr, e_data);
            end
            vectors++;
            if ({p0_rvalid, p1_rvalid} !== {(exp_rv == 0), (exp_rv == 1)}) begin
                miscompares++;
                $display("FAIL rand_rvalid[%0d]: got %b%b required port %0d", n, p0_rvalid, p1_rvalid, exp_rv);
            end
            if (exp_rv >= 0 && exp_rd_known) begin
                vectors++;
                if (((exp_rv == 0) ? p0_rdata : p1_rdata) !== exp_rd) begin
                    miscompares++;
                    $display("FAIL rand_rdata[%0d]: got %h/%h required %h on port %0d",
                             n, p0_rdata, p1_rdata, exp_rd, exp_rv);
                end
            end
            hold0 = p0_req && (g != 0);
            hold1 = p1_req && (g != 1);
            advance();
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        advance();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        for (int a = 0; a < (1 << AW); a++) m_known[a] = 1'b0;
        test_reset();
        test_write_seq();
        test_read_seq();
        test_contention();
        test_raw();
        test_idle_clears();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
